// File: rtl/gemm_pkg.sv
// Shared GEMM core defaults and the signed saturation helper used by the MAC row.
package gemm_pkg;

    localparam int LANES_DEF     = 16;
    localparam int INP_WIDTH_DEF = 8;
    localparam int WGT_WIDTH_DEF = 8;
    localparam int ACC_WIDTH_DEF = 32;

    // Clamp a signed value held in 65 bits to the signed range of 'width' bits.
    // The caller truncates the result to its own accumulator width.
    function automatic logic signed [64:0] sat_acc(input logic signed [64:0] value,
                                                  input int                  width);
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        hi = (65'sd1 <<< (width - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/systolic_lane.sv
// Single-lane two-stage MAC datapath: S1 registers the product and the
// accumulator operand, S2 registers the (optionally saturated) sum.
// Stage enables come from the row controller.
module systolic_lane
    import gemm_pkg::*;
#(
    parameter int INP_WIDTH = INP_WIDTH_DEF,
    parameter int WGT_WIDTH = WGT_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter bit SATURATE  = 1'b0,
    parameter bit USE_DSP   = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s1_en,
    input  logic                        s2_en,
    input  logic                        clr,
    input  logic                        mask,
    input  logic signed [INP_WIDTH-1:0] i,
    input  logic signed [WGT_WIDTH-1:0] w,
    input  logic signed [ACC_WIDTH-1:0] a,
    output logic signed [ACC_WIDTH-1:0] o
);

    localparam int PW = INP_WIDTH + WGT_WIDTH;
    localparam int SW = ACC_WIDTH + 1;

    logic signed [PW-1:0]        p_next;
    logic signed [PW-1:0]        p_reg;
    logic signed [ACC_WIDTH-1:0] a_next;
    logic signed [ACC_WIDTH-1:0] a_reg;
    logic                        mask_reg;
    logic signed [SW-1:0]        sum;
    logic signed [ACC_WIDTH-1:0] s_next;
    logic signed [ACC_WIDTH-1:0] o_reg;

    // The multiplier style only changes the mapping hint, never the function.
    generate
        if (USE_DSP) begin : g_mul_dsp
            (* use_dsp = "yes" *) logic signed [PW-1:0] prod;
            assign prod   = PW'(i) * PW'(w);
            assign p_next = prod;
        end else begin : g_mul_lut
            (* use_dsp = "no" *) logic signed [PW-1:0] prod;
            assign prod   = PW'(i) * PW'(w);
            assign p_next = prod;
        end
    endgenerate

    // Clear mode starts a fresh accumulation, so the incoming operand is dropped.
    assign a_next = clr ? '0 : a;

    // One extra bit so the carry out is visible to the saturation logic.
    assign sum = SW'(p_reg) + SW'(a_reg);

    // Masked-off lanes forward the captured operand untouched.
    generate
        if (SATURATE) begin : g_sat
            always_comb begin
                s_next = a_reg;
                if (mask_reg) begin
                    s_next = ACC_WIDTH'(sat_acc(65'(sum), ACC_WIDTH));
                end
            end
        end else begin : g_wrap
            always_comb begin
                s_next = a_reg;
                if (mask_reg) begin
                    s_next = ACC_WIDTH'(sum);
                end
            end
        end
    endgenerate

    // S1: capture product, operand and mask when the row accepts a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg    <= '0;
            a_reg    <= '0;
            mask_reg <= 1'b0;
        end else if (s1_en) begin
            p_reg    <= p_next;
            a_reg    <= a_next;
            mask_reg <= mask;
        end
    end

    // S2: result register, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_reg <= '0;
        end else if (s2_en) begin
            o_reg <= s_next;
        end
    end

    assign o = o_reg;

endmodule

// File: rtl/systolic_row_pipe.sv
// Pipelined MAC row: LANES independent o = a + i*w lanes behind a two-stage
// valid/ready pipeline. The row owns the handshake; lanes own the data.
module systolic_row_pipe
    import gemm_pkg::*;
#(
    parameter int LANES     = LANES_DEF,
    parameter int INP_WIDTH = INP_WIDTH_DEF,
    parameter int WGT_WIDTH = WGT_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter bit SATURATE  = 1'b0,
    parameter bit USE_DSP   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_clr,
    input  logic [LANES-1:0]             in_mask,
    input  logic [LANES*INP_WIDTH-1:0]   i_row,
    input  logic [LANES*WGT_WIDTH-1:0]   w_row,
    input  logic [LANES*ACC_WIDTH-1:0]   a_row,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*ACC_WIDTH-1:0]   o_row
);

    logic v1_reg;
    logic v2_reg;
    logic s1_adv;
    logic s2_adv;
    logic s1_en;
    logic s2_en;

    // A stage may move when it is empty or the stage after it is moving.
    // in_ready depends only on state and out_ready, never on in_valid.
    assign s2_adv   = !v2_reg || out_ready;
    assign s1_adv   = !v1_reg || s2_adv;
    assign in_ready = s1_adv;

    // Data registers only load when a real beat moves into the stage.
    assign s1_en = s1_adv && in_valid;
    assign s2_en = s2_adv && v1_reg;

    // Stage occupancy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
        end else begin
            if (s1_adv) begin
                v1_reg <= in_valid;
            end
            if (s2_adv) begin
                v2_reg <= v1_reg;
            end
        end
    end

    assign out_valid = v2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            systolic_lane #(
                .INP_WIDTH (INP_WIDTH),
                .WGT_WIDTH (WGT_WIDTH),
                .ACC_WIDTH (ACC_WIDTH),
                .SATURATE  (SATURATE),
                .USE_DSP   (USE_DSP)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .s1_en (s1_en),
                .s2_en (s2_en),
                .clr   (in_clr),
                .mask  (in_mask[gi]),
                .i     (i_row[gi*INP_WIDTH +: INP_WIDTH]),
                .w     (w_row[gi*WGT_WIDTH +: WGT_WIDTH]),
                .a     (a_row[gi*ACC_WIDTH +: ACC_WIDTH]),
                .o     (o_row[gi*ACC_WIDTH +: ACC_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_systolic_row_pipe.sv
// Bench for systolic_row_pipe: a wrapping and a saturating row share one
// stimulus stream; a queue-based model predicts every result beat.
module tb_systolic_row_pipe;

    localparam int L  = 16;
    localparam int RW = L * 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_clr;
    logic [L-1:0]  in_mask;
    logic [L*8-1:0] i_row;
    logic [L*8-1:0] w_row;
    logic [RW-1:0] a_row;
    logic          out_ready;

    logic          in_ready,  in_ready_s;
    logic          out_valid, out_valid_s;
    logic [RW-1:0] o_row,     o_row_s;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] q_wrap[$];
    logic [RW-1:0] q_sat[$];
    bit            stall_prev = 1'b0;
    logic [RW-1:0] prev_o, prev_os;

    always #5 clk = ~clk;

    systolic_row_pipe #(.LANES(L), .SATURATE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_clr(in_clr), .in_mask(in_mask), .i_row(i_row), .w_row(w_row),
        .a_row(a_row), .out_valid(out_valid), .out_ready(out_ready), .o_row(o_row)
    );

    systolic_row_pipe #(.LANES(L), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_clr(in_clr), .in_mask(in_mask), .i_row(i_row), .w_row(w_row),
        .a_row(a_row), .out_valid(out_valid_s), .out_ready(out_ready), .o_row(o_row_s)
    );

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: each lane is a + i*w on plain integers.
    function automatic logic [RW-1:0] model_row(input bit sat);
        logic [RW-1:0] r;
        longint iv, wv, av, s;
        r = '0;
        for (int k = 0; k < L; k++) begin
            iv = longint'($signed(i_row[k*8 +: 8]));
            wv = longint'($signed(w_row[k*8 +: 8]));
            av = in_clr ? 64'sd0 : longint'($signed(a_row[k*32 +: 32]));
            s  = in_mask[k] ? av + iv * wv : av;
            if (sat) begin
                if (s > 64'sd2147483647)  s = 64'sd2147483647;
                if (s < -64'sd2147483648) s = -64'sd2147483648;
            end
            r[k*32 +: 32] = s[31:0];
        end
        return r;
    endfunction

    // One clock: sample at the falling edge, score transfers, advance past the rising edge.
    task automatic do_cycle(output bit fin);
        bit fout;
        bit exp_ready;
        @(negedge clk);
        exp_ready = !(q_wrap.size() == 2 && !out_ready);
        chk("in_ready", in_ready, exp_ready);
        chk("in_ready_sat", in_ready_s, exp_ready);
        chk("out_valid_pair", out_valid_s, out_valid);
        chk("spurious_out", (out_valid && q_wrap.size() == 0), 1'b0);
        if (stall_prev) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_hold", o_row, prev_o);
            chk("stall_hold_sat", o_row_s, prev_os);
        end
        fin  = in_valid && in_ready;
        fout = out_valid && out_ready;
        if (fout && q_wrap.size() > 0) begin
            chk("o_row_wrap", o_row, q_wrap.pop_front());
            chk("o_row_sat", o_row_s, q_sat.pop_front());
        end
        if (fin) begin
            q_wrap.push_back(model_row(1'b0));
            q_sat.push_back(model_row(1'b1));
        end
        stall_prev = out_valid && !out_ready;
        prev_o     = o_row;
        prev_os    = o_row_s;
        @(posedge clk);
        #1;
    endtask

    // Issue one beat into an empty pipe with out_ready high and check 2-cycle latency.
    task automatic run_single(output logic [RW-1:0] res, output logic [RW-1:0] res_s);
        bit f;
        in_valid = 1'b1;
        do_cycle(f);
        chk("single_accept", f, 1'b1);
        in_valid = 1'b0;
        chk("latency_c1", out_valid, 1'b0);
        do_cycle(f);
        chk("latency_c2", out_valid, 1'b1);
        res   = o_row;
        res_s = o_row_s;
        do_cycle(f);
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < L; k++) begin
            i_row[k*8 +: 8] = 8'($urandom);
            w_row[k*8 +: 8] = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       a_row[k*32 +: 32] = 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
                1:       a_row[k*32 +: 32] = 32'h8000_0000 + 32'($urandom_range(0, 255));
                default: a_row[k*32 +: 32] = $urandom;
            endcase
        end
        in_mask = 16'($urandom);
        in_clr  = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] r, rs;
        bit f;
        int sent, cyc;

        rst_n = 1'b0; in_valid = 1'b0; in_clr = 1'b0; in_mask = '0;
        i_row = '0; w_row = '0; a_row = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_o_row", o_row, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp: lane k gets i=k-8, w=3, a=100.
        in_mask = '1; in_clr = 1'b0;
        for (int k = 0; k < L; k++) begin
            i_row[k*8 +: 8]   = 8'(k - 8);
            w_row[k*8 +: 8]   = 8'd3;
            a_row[k*32 +: 32] = 32'd100;
        end
        run_single(r, rs);
        for (int k = 0; k < L; k++) chk("ramp_lane", r[k*32 +: 32], 32'(100 + 3 * (k - 8)));
        chk("ramp_lane0", r[31:0], 32'd76);

        // Clear mode ignores a: (-128)*(-128) = 16384.
        in_clr = 1'b1;
        for (int k = 0; k < L; k++) begin
            i_row[k*8 +: 8]   = 8'h80;
            w_row[k*8 +: 8]   = 8'h80;
            a_row[k*32 +: 32] = 32'h7FFF_FFFF;
        end
        run_single(r, rs);
        chk("clr_lane0", r[31:0], 32'd16384);
        chk("clr_lane15_sat", rs[15*32 +: 32], 32'd16384);

        // Overflow: 0x7FFFFFF0 + 127*127 (0x3F01) = 0x80003EF1 wrapped, clamps when saturating.
        in_clr = 1'b0;
        for (int k = 0; k < L; k++) begin
            i_row[k*8 +: 8]   = 8'd127;
            w_row[k*8 +: 8]   = 8'd127;
            a_row[k*32 +: 32] = 32'h7FFF_FFF0;
        end
        run_single(r, rs);
        chk("sat_clamp", rs[31:0], 32'h7FFF_FFFF);
        chk("wrap_overflow", r[31:0], 32'h8000_3EF1);

        // Mask 0xAAAA: odd lanes add 1*1, even lanes pass a=5.
        in_mask = 16'hAAAA;
        for (int k = 0; k < L; k++) begin
            i_row[k*8 +: 8]   = 8'd1;
            w_row[k*8 +: 8]   = 8'd1;
            a_row[k*32 +: 32] = 32'd5;
        end
        run_single(r, rs);
        chk("mask_even", r[0 +: 32], 32'd5);
        chk("mask_odd", r[32 +: 32], 32'd6);
        chk("mask_odd15", rs[15*32 +: 32], 32'd6);

        // Random traffic with random backpressure.
        sent = 0;
        cyc  = 0;
        while (sent < 200 && cyc < 4000) begin
            randomize_inputs();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            do_cycle(f);
            if (f) sent++;
            cyc++;
        end
        chk("rand_sent", 32'(sent), 32'd200);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (q_wrap.size() > 0 && cyc < 20) begin
            do_cycle(f);
            cyc++;
        end
        chk("drain_empty", 32'(q_wrap.size()), 32'd0);

        // Fill both stages while stalled, then reset mid-stall.
        out_ready = 1'b0;
        randomize_inputs();
        in_valid = 1'b1;
        do_cycle(f);
        randomize_inputs();
        do_cycle(f);
        randomize_inputs();
        do_cycle(f);
        chk("full_stall_accept", f, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_o_row", o_row, '0);
        chk("midrst_o_row_sat", o_row_s, '0);
        chk("midrst_in_ready", in_ready, 1'b1);
        q_wrap.delete();
        q_sat.delete();
        stall_prev = 1'b0;
        in_valid   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_mask = '1; in_clr = 1'b0;
        for (int k = 0; k < L; k++) begin
            i_row[k*8 +: 8]   = 8'(k);
            w_row[k*8 +: 8]   = 8'd2;
            a_row[k*32 +: 32] = 32'd1;
        end
        run_single(r, rs);
        chk("post_rst_lane3", r[3*32 +: 32], 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
